// File: rtl/imm_ext_pipe_if.sv
// Handshake and data bundle for imm_ext_pipe: decode-side input channel,
// execute-side output channel and the reserved-mode error counter.
interface imm_ext_pipe_if #(
  parameter int WIDTH     = 32,
  parameter int ERR_CNT_W = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [1:0]           ImmSrc;
  logic [23:0]          Istr;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     ExtImm;
  logic                 err;
  logic [ERR_CNT_W-1:0] err_cnt;

  modport master (
    output in_valid, ImmSrc, Istr, out_ready,
    input  in_ready, out_valid, ExtImm, err, err_cnt
  );

  modport slave (
    input  in_valid, ImmSrc, Istr, out_ready,
    output in_ready, out_valid, ExtImm, err, err_cnt
  );
endinterface

// File: rtl/imm_ext_pipe.sv
// Two-stage valid/ready immediate extender (data-proc, memory, branch, reserved).
// Define IMM_ROT_EN to turn ImmSrc=00 into the ARM rotated 8-bit immediate.
module imm_ext_pipe #(
  parameter int WIDTH     = 32,
  parameter int ERR_CNT_W = 8
) (
  input logic           clk,
  input logic           rst_n,
  imm_ext_pipe_if.slave bus
);
  logic                 s1_valid_q, s1_valid_d;
  logic [1:0]           s1_src_q;
  logic [23:0]          s1_istr_q;
  logic                 s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0]     s2_imm_q, s2_imm_d;
  logic                 s2_err_q, s2_err_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic                 s2_free, load_s1, move_s2;

  // Ready chain: S2 frees on a consumer handshake, S1 may refill while draining.
  always_comb begin
    s2_free  = !s2_valid_q || bus.out_ready;
    move_s2  = s1_valid_q && s2_free;
    load_s1  = bus.in_valid && (!s1_valid_q || s2_free);
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    if (load_s1)
      s1_valid_d = 1'b1;
    else if (move_s2)
      s1_valid_d = 1'b0;
    s2_valid_d = s2_valid_q;
    if (s2_free)
      s2_valid_d = s1_valid_q;
  end

`ifdef IMM_ROT_EN
  logic [31:0] rot_base, rot_res;
  logic [4:0]  rot_amt;

  // Rotation is always on a 32-bit field; a zero amount shifts the left part out.
  always_comb begin
    rot_base = {24'd0, s1_istr_q[7:0]};
    rot_amt  = {s1_istr_q[11:8], 1'b0};
    rot_res  = (rot_base >> rot_amt) | (rot_base << (6'd32 - {1'b0, rot_amt}));
  end
`endif

  always_comb begin
    s2_imm_d = '0;
    s2_err_d = 1'b0;
    case (s1_src_q)
      2'b00: begin
`ifdef IMM_ROT_EN
        s2_imm_d = WIDTH'(rot_res);
`else
        s2_imm_d = WIDTH'(s1_istr_q[7:0]);
`endif
      end
      2'b01:   s2_imm_d = WIDTH'(s1_istr_q[11:0]);
      2'b10:   s2_imm_d = WIDTH'($signed({s1_istr_q, 2'b00}));
      default: s2_err_d = 1'b1;
    endcase
  end

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (s2_valid_q && bus.out_ready && s2_err_q && (err_cnt_q != '1))
      err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_src_q   <= '0;
      s1_istr_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_imm_q   <= '0;
      s2_err_q   <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      if (load_s1) begin
        s1_src_q  <= bus.ImmSrc;
        s1_istr_q <= bus.Istr;
      end
      s2_valid_q <= s2_valid_d;
      if (move_s2) begin
        s2_imm_q <= s2_imm_d;
        s2_err_q <= s2_err_d;
      end
      err_cnt_q <= err_cnt_d;
    end
  end

  assign bus.in_ready  = !s1_valid_q || s2_free;
  assign bus.out_valid = s2_valid_q;
  assign bus.ExtImm    = s2_imm_q;
  assign bus.err       = s2_err_q;
  assign bus.err_cnt   = err_cnt_q;
endmodule
